// File: rtl/inst_cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
// Geometry: 64 lines of 4 x 32-bit words.
package inst_cache_pkg;
  localparam int WORD = 32;
  localparam int INDEX_BITS = 6;
  localparam int OFFSET_BITS = 2;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;
  localparam int TAG_BITS = WORD - INDEX_BITS - OFFSET_BITS - 2;
  localparam logic [WORD-1:0] INST_NOP = 32'h0340_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RECV = 2'd2
  } state_t;

  typedef logic [INDEX_BITS-1:0] index_t;
  typedef logic [OFFSET_BITS-1:0] offset_t;
  typedef logic [TAG_BITS-1:0] tag_t;

  function automatic tag_t tag_of(input logic [WORD-1:0] a);
    return a[WORD-1 -: TAG_BITS];
  endfunction

  function automatic index_t index_of(input logic [WORD-1:0] a);
    return a[OFFSET_BITS+2 +: INDEX_BITS];
  endfunction

  function automatic offset_t offset_of(input logic [WORD-1:0] a);
    return a[2 +: OFFSET_BITS];
  endfunction
endpackage

// File: rtl/inst_cache_ram.sv
// Tag/data storage with one combinational read port, one word-write port
// and a valid-bit vector supporting bulk clear.
module inst_cache_ram
  import inst_cache_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  index_t          rd_index,
  input  offset_t         rd_offset,
  output logic            rd_valid,
  output tag_t            rd_tag,
  output logic [WORD-1:0] rd_data,
  input  logic            wr_en,
  input  index_t          wr_index,
  input  offset_t         wr_offset,
  input  logic [WORD-1:0] wr_data,
  input  logic            fill_start,
  input  logic            fill_done,
  input  tag_t            fill_tag,
  input  logic            inv
);
  tag_t             tags [LINES];
  logic [WORD-1:0]  data [LINES*WORDS];
  logic [LINES-1:0] valid;

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[{rd_index, rd_offset}];

  always_ff @(posedge clk) begin
    if (wr_en)
      data[{wr_index, wr_offset}] <= wr_data;
    if (fill_done)
      tags[wr_index] <= fill_tag;
  end

  // inv beats a completing fill so the line stays invalid
  always_ff @(posedge clk) begin
    if (rst)
      valid <= '0;
    else if (inv)
      valid <= '0;
    else if (fill_start)
      valid[wr_index] <= 1'b0;
    else if (fill_done)
      valid[wr_index] <= 1'b1;
  end
endmodule

// File: rtl/inst_cache.sv
// Blocking direct-mapped instruction cache answering IF1 fetches;
// refills one line at a time from the memory read port.
module inst_cache
  import inst_cache_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [WORD-1:0] req_addr,
  output logic            ready,
  output logic [WORD-1:0] inst,
  input  logic            inv,
  output logic            mem_rd_req,
  output logic [WORD-1:0] mem_rd_addr,
  input  logic            mem_rd_ready,
  input  logic            mem_rd_valid,
  input  logic [WORD-1:0] mem_rd_data,
  input  logic            mem_rd_last
);
  state_t          state;
  offset_t         cnt;
  logic [WORD-1:0] line_addr;
  logic            rd_valid;
  tag_t            rd_tag;
  logic [WORD-1:0] rd_data;
  logic            hit;
  logic            beat;
  logic            last;
  logic            unused_lsb;

  assign unused_lsb = ^req_addr[1:0];

  assign hit   = rd_valid && (rd_tag == tag_of(req_addr));
  assign ready = req_valid && hit && (state == S_IDLE) && !inv;
  assign inst  = ready ? rd_data : INST_NOP;

  assign beat = (state == S_RECV) && mem_rd_valid && !rst;
  assign last = (cnt == offset_t'(WORDS-1));

  assign mem_rd_addr = line_addr;

  inst_cache_ram u_ram (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (index_of(req_addr)),
    .rd_offset  (offset_of(req_addr)),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_en      (beat),
    .wr_index   (index_of(line_addr)),
    .wr_offset  (cnt),
    .wr_data    (mem_rd_data),
    .fill_start (beat && (cnt == '0)),
    .fill_done  (beat && last),
    .fill_tag   (tag_of(line_addr)),
    .inv        (inv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      mem_rd_req <= 1'b0;
      line_addr  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid && !hit) begin
            line_addr  <= {req_addr[WORD-1:OFFSET_BITS+2],
                           {(OFFSET_BITS+2){1'b0}}};
            mem_rd_req <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_rd_ready) begin
            mem_rd_req <= 1'b0;
            cnt        <= '0;
            state      <= S_RECV;
          end
        end
        S_RECV: begin
          if (mem_rd_valid) begin
            cnt <= cnt + 1'b1;
            if (last)
              state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // the beat counter is authoritative; a stray last marker is only flagged
  always_ff @(posedge clk) begin
    if (!rst && state == S_RECV && mem_rd_valid)
      assert (mem_rd_last == last)
        else $error("inst_cache: mem_rd_last out of step with beat count");
  end
endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cold/conflict misses, stalls,
// invalidation, reset mid-refill and dropped requests.
module tb_inst_cache;
  localparam logic [31:0] NOP = 32'h0340_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        ready;
  logic [31:0] inst;
  logic        inv;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ready;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_rd_last;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  inst_cache dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .ready        (ready),
    .inst         (inst),
    .inv          (inv),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_last  (mem_rd_last)
  );

  task automatic chk(input string tg, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tg, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    mem_rd_valid = 1'b1;
    mem_rd_data  = d;
    mem_rd_last  = l;
  endtask

  task automatic refill(input logic [31:0] a,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input bit inv_last);
    logic [31:0] d [4];
    logic [1:0]  o;
    d = '{d0, d1, d2, d3};
    o = a[3:2];
    req_valid = 1'b1;
    req_addr = a;
    mem_rd_ready = 1'b1;
    settle;
    chk("miss_ready", ready, 0);
    chk("miss_inst", inst, NOP);
    tick;
    settle;
    chk("req", mem_rd_req, 1);
    chk("req_addr", mem_rd_addr, a & ~32'hF);
    chk("req_ready", ready, 0);
    tick;
    mem_rd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat(d[k], k == 3);
      inv = inv_last && (k == 3);
      settle;
      chk("recv_ready", ready, 0);
      chk("recv_inst", inst, NOP);
      tick;
    end
    mem_rd_valid = 1'b0;
    mem_rd_last = 1'b0;
    inv = 1'b0;
    settle;
    if (inv_last) begin
      chk("inv_last_ready", ready, 0);
    end else begin
      chk("hit_ready", ready, 1);
      chk("hit_inst", inst, d[o]);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h1C00_0000;
    inv = 1'b0;
    mem_rd_ready = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    mem_rd_last = 1'b0;
    tick;
    tick;
    settle;
    chk("rst_ready", ready, 0);
    chk("rst_inst", inst, NOP);
    chk("rst_req", mem_rd_req, 0);
    rst = 1'b0;
    req_valid = 1'b0;
    tick;

    // 1: cold miss
    refill(32'h1C00_0000, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0);
    req_addr = 32'h1C00_000C;
    settle;
    chk("t1_off3", inst, 32'h44);
    req_addr = 32'h1C00_0004;
    settle;
    chk("t1_off1", inst, 32'h22);
    tick;

    // 2: conflict on index 0
    refill(32'h1C00_0400, 32'h55, 32'h66, 32'h77, 32'h88, 1'b0);
    req_addr = 32'h1C00_0408;
    settle;
    chk("t2_off2", inst, 32'h77);
    req_addr = 32'h1C00_0000;
    settle;
    chk("t2_evicted", ready, 0);
    req_valid = 1'b0;
    tick;

    // 3: stalled memory
    req_valid = 1'b1;
    req_addr = 32'h2000_0010;
    mem_rd_ready = 1'b0;
    settle;
    chk("t3_miss", ready, 0);
    tick;
    for (int k = 0; k < 3; k++) begin
      settle;
      chk("t3_req_hold", mem_rd_req, 1);
      chk("t3_addr_hold", mem_rd_addr, 32'h2000_0010);
      tick;
    end
    mem_rd_ready = 1'b1;
    settle;
    chk("t3_req_acc", mem_rd_req, 1);
    tick;
    mem_rd_ready = 1'b0;
    beat(32'hC1, 1'b0);
    settle;
    chk("t3_req_drop", mem_rd_req, 0);
    tick;
    beat(32'hC2, 1'b0);
    tick;
    mem_rd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle;
      chk("t3_gap_ready", ready, 0);
      tick;
    end
    beat(32'hC3, 1'b0);
    tick;
    beat(32'hC4, 1'b1);
    settle;
    chk("t3_last_ready", ready, 0);
    tick;
    mem_rd_valid = 1'b0;
    mem_rd_last = 1'b0;
    settle;
    chk("t3_hit", ready, 1);
    chk("t3_w0", inst, 32'hC1);
    req_addr = 32'h2000_0018;
    settle;
    chk("t3_w2", inst, 32'hC3);
    req_addr = 32'h2000_001C;
    settle;
    chk("t3_w3", inst, 32'hC4);

    // 4: invalidate in idle, then on the last beat
    req_addr = 32'h2000_0010;
    inv = 1'b1;
    settle;
    chk("t4_inv_ready", ready, 0);
    chk("t4_inv_inst", inst, NOP);
    tick;
    inv = 1'b0;
    refill(32'h2000_0010, 32'hD1, 32'hD2, 32'hD3, 32'hD4, 1'b0);
    tick;
    refill(32'h3000_0020, 32'hE1, 32'hE2, 32'hE3, 32'hE4, 1'b1);
    refill(32'h3000_0024, 32'hF1, 32'hF2, 32'hF3, 32'hF4, 1'b0);
    tick;

    // 5: reset after two beats
    req_valid = 1'b1;
    req_addr = 32'h4000_0030;
    mem_rd_ready = 1'b1;
    tick;
    tick;
    mem_rd_ready = 1'b0;
    beat(32'hB1, 1'b0);
    tick;
    beat(32'hB2, 1'b0);
    tick;
    rst = 1'b1;
    beat(32'hB3, 1'b0);
    tick;
    rst = 1'b0;
    req_valid = 1'b0;
    beat(32'hB4, 1'b1);
    settle;
    chk("t5_req", mem_rd_req, 0);
    chk("t5_ready", ready, 0);
    tick;
    mem_rd_valid = 1'b0;
    mem_rd_last = 1'b0;
    settle;
    chk("t5_idle_req", mem_rd_req, 0);
    refill(32'h4000_0038, 32'h91, 32'h92, 32'h93, 32'h94, 1'b0);
    tick;

    // 6: no request, then request dropped during refill
    req_valid = 1'b0;
    req_addr = 32'h5000_0040;
    settle;
    chk("t6_ready", ready, 0);
    chk("t6_req", mem_rd_req, 0);
    tick;
    settle;
    chk("t6_still_idle", mem_rd_req, 0);
    req_valid = 1'b1;
    mem_rd_ready = 1'b1;
    tick;
    tick;
    mem_rd_ready = 1'b0;
    req_valid = 1'b0;
    req_addr = 32'h6000_0000;
    beat(32'hA1, 1'b0);
    tick;
    req_valid = 1'b1;
    req_addr = 32'h4000_0030;
    beat(32'hA2, 1'b0);
    settle;
    chk("t6_other_line", ready, 0);
    tick;
    req_valid = 1'b0;
    beat(32'hA3, 1'b0);
    tick;
    beat(32'hA4, 1'b1);
    tick;
    mem_rd_valid = 1'b0;
    mem_rd_last = 1'b0;
    req_valid = 1'b1;
    req_addr = 32'h5000_0044;
    settle;
    chk("t6_done_ready", ready, 1);
    chk("t6_done_inst", inst, 32'hA2);
    req_addr = 32'h4000_0030;
    settle;
    chk("t6_prev_line", inst, 32'h91);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
